// File: rtl/crypto_ctrl_pkg.sv
// Shared opcodes, core ids and tracker states for the crypto command path.
// Used by crypto_cmd_scheduler and its command interface.
package crypto_ctrl_pkg;
   localparam logic [1:0] OP_AES_ENC = 2'b00;
   localparam logic [1:0] OP_AES_DEC = 2'b01;
   localparam logic [1:0] OP_SHA     = 2'b10;
   localparam logic [1:0] OP_RSVD    = 2'b11;

   localparam int CORE_AES = 0;
   localparam int CORE_SHA = 1;
   localparam int NCORE    = 2;

   typedef enum logic {
      TRK_IDLE = 1'b0,
      TRK_BUSY = 1'b1
   } trk_state_t;

   function automatic int cmd_width(input int addrw);
      return 2 + 2 * addrw;
   endfunction
endpackage

// File: rtl/crypto_cmd_scheduler_if.sv
// Host command channel: valid/ready handshake carrying opcode and addresses.
// The host side is the master; the scheduler is the slave.
interface crypto_cmd_scheduler_if #(
   parameter int ADDRW = 24
) ();
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [ADDRW-1:0] cmd_src;
   logic [ADDRW-1:0] cmd_dst;

   modport master (
      output cmd_valid, cmd_op, cmd_src, cmd_dst,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_src, cmd_dst,
      output cmd_ready
   );
endinterface

// File: rtl/crypto_cmd_scheduler_sync_fifo.sv
// sync_fifo: generic in-order queue, valid/ready push, peek/pop head, count.
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_valid,
   output logic                     push_ready,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic                     head_valid,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_q;
   logic [AW-1:0]    rd_q;
   logic             do_push;
   logic             do_pop;

   // No pass-through: a full queue refuses even while popping.
   assign push_ready = (count != (AW+1)'(DEPTH));
   assign head_valid = (count != '0);
   assign head_data  = mem[rd_q];
   assign do_push    = push_valid && push_ready;
   assign do_pop     = pop && head_valid;

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         count <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/crypto_cmd_scheduler.sv
// In-order AES/SHA command dispatcher with one job in flight per core.
// Optional per-job watchdog: define CRYPTO_SCHED_TIMEOUT_EN.
module crypto_cmd_scheduler
   import crypto_ctrl_pkg::*;
#(
   parameter int ADDRW          = 24,
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   clk,
   input  logic                   rst_n,
   crypto_cmd_scheduler_if.slave  cmd,
   output logic                   aes_start,
   output logic                   aes_decrypt,
   output logic [ADDRW-1:0]       aes_src,
   output logic [ADDRW-1:0]       aes_dst,
   input  logic                   aes_done,
   output logic                   sha_start,
   output logic [ADDRW-1:0]       sha_src,
   output logic [ADDRW-1:0]       sha_dst,
   input  logic                   sha_done,
   output logic                   cmpl_valid,
   output logic                   cmpl_core,
   output logic                   err_illegal,
`ifdef CRYPTO_SCHED_TIMEOUT_EN
   output logic                   err_timeout,
`endif
   output logic [$clog2(DEPTH):0] queue_count
);
   localparam int CW = cmd_width(ADDRW);

   logic [CW-1:0]    head;
   logic             head_valid;
   logic             pop;
   logic [1:0]       h_op;
   logic [ADDRW-1:0] h_src;
   logic [ADDRW-1:0] h_dst;

   trk_state_t       st_q [NCORE];
   trk_state_t       st_d [NCORE];
   logic [NCORE-1:0] busy;
   logic [NCORE-1:0] done;
   logic [NCORE-1:0] go;
   logic [NCORE-1:0] expire;
   logic [NCORE-1:0] evt;
   logic             go_ill;

   logic sel_v, sel_core, sel_to;
   logic pend_q, pend_d, pend_to_q, pend_to_d;

   sync_fifo #(.WIDTH(CW), .DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (cmd.cmd_valid),
      .push_ready (cmd.cmd_ready),
      .push_data  ({cmd.cmd_op, cmd.cmd_src, cmd.cmd_dst}),
      .pop        (pop),
      .head_valid (head_valid),
      .head_data  (head),
      .count      (queue_count)
   );

   assign h_op  = head[CW-1 -: 2];
   assign h_src = head[2*ADDRW-1 -: ADDRW];
   assign h_dst = head[ADDRW-1:0];

   always_comb begin
      for (int i = 0; i < NCORE; i++)
         busy[i] = (st_q[i] == TRK_BUSY);
   end

   assign done = {sha_done, aes_done} & busy;
   assign evt  = done | expire;

   // Strict in-order: a blocked head stalls everything behind it.
   always_comb begin
      go     = '0;
      go_ill = 1'b0;
      if (head_valid) begin
         unique case (1'b1)
            (h_op == OP_RSVD): go_ill = 1'b1;
            !h_op[1]:          go[CORE_AES] = !busy[CORE_AES];
            default:           go[CORE_SHA] = !busy[CORE_SHA];
         endcase
      end
   end

   assign pop = go_ill | (|go);

   always_comb begin
      for (int i = 0; i < NCORE; i++) begin
         st_d[i] = st_q[i];
         unique case (st_q[i])
            TRK_IDLE: if (go[i]) st_d[i] = TRK_BUSY;
            TRK_BUSY: if (evt[i]) st_d[i] = TRK_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCORE; i++)
         st_q[i] <= rst_n ? st_d[i] : TRK_IDLE;
   end

`ifdef CRYPTO_SCHED_TIMEOUT_EN
   logic [31:0] age_q [NCORE];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NCORE; i++) begin
         if (!rst_n || !(busy[i] && st_d[i] == TRK_BUSY))
            age_q[i] <= '0;
         else
            age_q[i] <= age_q[i] + 32'd1;
      end
   end

   // A done in the expiry cycle wins over the watchdog.
   always_comb begin
      for (int i = 0; i < NCORE; i++)
         expire[i] = busy[i] && !done[i] &&
                     (age_q[i] == 32'(TIMEOUT_CYCLES - 1));
   end
`else
   assign expire = '0;
`endif

   // AES reported first; a simultaneous SHA event waits one cycle.
   always_comb begin
      sel_v     = 1'b0;
      sel_core  = 1'b0;
      sel_to    = 1'b0;
      pend_d    = pend_q;
      pend_to_d = pend_to_q;
      if (evt[CORE_AES]) begin
         sel_v  = 1'b1;
         sel_to = expire[CORE_AES];
         if (evt[CORE_SHA]) begin
            pend_d    = 1'b1;
            pend_to_d = expire[CORE_SHA];
         end
      end else if (pend_q) begin
         sel_v     = 1'b1;
         sel_core  = 1'b1;
         sel_to    = pend_to_q;
         pend_d    = evt[CORE_SHA];
         pend_to_d = expire[CORE_SHA];
      end else if (evt[CORE_SHA]) begin
         sel_v    = 1'b1;
         sel_core = 1'b1;
         sel_to   = expire[CORE_SHA];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_q     <= 1'b0;
         pend_to_q  <= 1'b0;
         cmpl_valid <= 1'b0;
         cmpl_core  <= 1'b0;
      end else begin
         pend_q     <= pend_d;
         pend_to_q  <= pend_to_d;
         cmpl_valid <= sel_v && !sel_to;
         if (sel_v) cmpl_core <= sel_core;
      end
   end

`ifdef CRYPTO_SCHED_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) err_timeout <= 1'b0;
      else        err_timeout <= sel_v && sel_to;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         aes_start   <= 1'b0;
         sha_start   <= 1'b0;
         err_illegal <= 1'b0;
         aes_decrypt <= 1'b0;
         aes_src     <= '0;
         aes_dst     <= '0;
         sha_src     <= '0;
         sha_dst     <= '0;
      end else begin
         aes_start   <= go[CORE_AES];
         sha_start   <= go[CORE_SHA];
         err_illegal <= go_ill;
         if (go[CORE_AES]) begin
            aes_decrypt <= h_op[0];
            aes_src     <= h_src;
            aes_dst     <= h_dst;
         end
         if (go[CORE_SHA]) begin
            sha_src <= h_src;
            sha_dst <= h_dst;
         end
      end
   end
endmodule

// File: tb/tb_crypto_cmd_scheduler.sv
// Bench for crypto_cmd_scheduler: directed plan steps plus random traffic,
// every cycle checked against a transaction-level queue/busy model.
module tb_crypto_cmd_scheduler;
   import crypto_ctrl_pkg::*;

   localparam int ADDRW = 24;
   localparam int DEPTH = 4;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
   localparam int TO = 16;
`else
   localparam int TO = 1024;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic             aes_done = 1'b0;
   logic             sha_done = 1'b0;
   logic             aes_start, aes_decrypt, sha_start;
   logic [ADDRW-1:0] aes_src, aes_dst, sha_src, sha_dst;
   logic             cmpl_valid, cmpl_core, err_illegal;
   logic [2:0]       queue_count;
`ifdef CRYPTO_SCHED_TIMEOUT_EN
   logic             err_timeout;
`endif

   crypto_cmd_scheduler_if #(.ADDRW(ADDRW)) bus ();

   crypto_cmd_scheduler #(
      .ADDRW          (ADDRW),
      .DEPTH          (DEPTH),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd         (bus),
      .aes_start   (aes_start),
      .aes_decrypt (aes_decrypt),
      .aes_src     (aes_src),
      .aes_dst     (aes_dst),
      .aes_done    (aes_done),
      .sha_start   (sha_start),
      .sha_src     (sha_src),
      .sha_dst     (sha_dst),
      .sha_done    (sha_done),
      .cmpl_valid  (cmpl_valid),
      .cmpl_core   (cmpl_core),
      .err_illegal (err_illegal),
`ifdef CRYPTO_SCHED_TIMEOUT_EN
      .err_timeout (err_timeout),
`endif
      .queue_count (queue_count)
   );

   typedef struct {
      logic [1:0]       op;
      logic [ADDRW-1:0] src;
      logic [ADDRW-1:0] dst;
   } cmd_t;

   typedef struct {
      bit core;
      bit to;
   } ev_t;

   cmd_t             mq [$];
   ev_t              eq [$];
   bit               busy_m [2];
   int               age_m [2];
   logic             la_dec;
   logic [ADDRW-1:0] la_src, la_dst, ls_src, ls_dst;
   int               n_cmp = 0;
   int               n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // One clock: predict from model state, advance, then compare.
   task automatic tick();
      bit   acc, popx, ad, sd, ato, sto, ea, es, ei;
      cmd_t f, nc;
      ev_t  e;
      acc  = bus.cmd_valid && (mq.size() != DEPTH);
      nc   = '{bus.cmd_op, bus.cmd_src, bus.cmd_dst};
      popx = 1'b0;
      if (mq.size() > 0) begin
         f    = mq[0];
         popx = (f.op == OP_RSVD) ||
                (f.op[1] ? !busy_m[1] : !busy_m[0]);
      end
      ad  = aes_done && busy_m[0];
      sd  = sha_done && busy_m[1];
      ato = busy_m[0] && !ad && (age_m[0] == TO);
      sto = busy_m[1] && !sd && (age_m[1] == TO);
      if (ad || ato) eq.push_back('{1'b0, ato});
      if (sd || sto) eq.push_back('{1'b1, sto});
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (busy_m[i]) age_m[i]++;
      if (ad || ato) busy_m[0] = 1'b0;
      if (sd || sto) busy_m[1] = 1'b0;
      ea = 1'b0; es = 1'b0; ei = 1'b0;
      if (popx) begin
         f = mq.pop_front();
         if (f.op == OP_RSVD) ei = 1'b1;
         else if (!f.op[1]) begin
            ea = 1'b1; busy_m[0] = 1'b1; age_m[0] = 1;
            la_dec = f.op[0]; la_src = f.src; la_dst = f.dst;
         end else begin
            es = 1'b1; busy_m[1] = 1'b1; age_m[1] = 1;
            ls_src = f.src; ls_dst = f.dst;
         end
      end
      if (acc) mq.push_back(nc);
      chk("aes_start", 64'(aes_start), 64'(ea));
      chk("sha_start", 64'(sha_start), 64'(es));
      chk("err_illegal", 64'(err_illegal), 64'(ei));
      chk("aes_fields", 64'({aes_decrypt, aes_src, aes_dst}),
          64'({la_dec, la_src, la_dst}));
      chk("sha_fields", 64'({sha_src, sha_dst}), 64'({ls_src, ls_dst}));
      if (eq.size() > 0) begin
         e = eq.pop_front();
         chk("cmpl", 64'({cmpl_valid, cmpl_core}), 64'({!e.to, e.core}));
`ifdef CRYPTO_SCHED_TIMEOUT_EN
         chk("err_timeout", 64'(err_timeout), 64'(e.to));
`endif
      end else begin
         chk("cmpl_valid", 64'(cmpl_valid), 64'(0));
`ifdef CRYPTO_SCHED_TIMEOUT_EN
         chk("err_timeout", 64'(err_timeout), 64'(0));
`endif
      end
      chk("queue_count", 64'(queue_count), 64'(mq.size()));
      chk("cmd_ready", 64'(bus.cmd_ready), 64'(mq.size() != DEPTH));
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0;
      aes_done = 1'b0;
      sha_done = 1'b0;
      repeat (n) @(posedge clk);
      #1;
      mq.delete();
      eq.delete();
      busy_m = '{1'b0, 1'b0};
      age_m  = '{0, 0};
      la_dec = 1'b0; la_src = '0; la_dst = '0;
      ls_src = '0; ls_dst = '0;
      chk("rst_pulses", 64'({aes_start, sha_start, cmpl_valid, err_illegal}),
          64'(0));
      chk("rst_addr", 64'({aes_decrypt, aes_src, aes_dst}), 64'(0));
      chk("rst_sha_addr", 64'({sha_src, sha_dst}), 64'(0));
      chk("rst_count", 64'(queue_count), 64'(0));
      chk("rst_ready", 64'(bus.cmd_ready), 64'(1));
      rst_n = 1'b1;
   endtask

   task automatic push(input logic [1:0] op, input logic [ADDRW-1:0] s,
                       input logic [ADDRW-1:0] d);
      bus.cmd_valid = 1'b1;
      bus.cmd_op = op; bus.cmd_src = s; bus.cmd_dst = d;
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse(input logic a, input logic s);
      aes_done = a; sha_done = s;
      tick();
      aes_done = 1'b0; sha_done = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 200 &&
           (mq.size() > 0 || busy_m[0] || busy_m[1]); k++) begin
         aes_done = busy_m[0];
         sha_done = busy_m[1];
         tick();
      end
      aes_done = 1'b0; sha_done = 1'b0;
      idle(3);
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_op = '0; bus.cmd_src = '0; bus.cmd_dst = '0;
      do_reset(2);

      // Single AES job, done five cycles after start.
      push(OP_AES_ENC, 24'h000100, 24'h000200);
      idle(1);
      chk("t1_start", 64'({aes_start, aes_decrypt}), 64'(2'b10));
      chk("t1_src", 64'({aes_src, aes_dst}), 64'h000100_000200);
      idle(4);
      pulse(1'b1, 1'b0);
      chk("t1_cmpl", 64'({cmpl_valid, cmpl_core}), 64'(2'b10));
      idle(2);

      // AES, SHA, AES: second AES stalls behind a busy core.
      push(OP_AES_ENC, 24'h000010, 24'h000020);
      push(OP_SHA, 24'h000030, 24'h000040);
      push(OP_AES_DEC, 24'h000050, 24'h000060);
      idle(3);
      chk("t2_stall_cnt", 64'(queue_count), 64'(1));
      pulse(1'b1, 1'b0);
      idle(1);
      chk("t2_restart", 64'({aes_start, aes_decrypt}), 64'(2'b11));
      // Simultaneous dones: AES then SHA on consecutive cycles.
      pulse(1'b1, 1'b1);
      chk("t5_first", 64'({cmpl_valid, cmpl_core}), 64'(2'b10));
      idle(1);
      chk("t5_second", 64'({cmpl_valid, cmpl_core}), 64'(2'b11));
      idle(2);

      // Fill the queue with both cores busy.
      push(OP_AES_ENC, 24'h000111, 24'h000222);
      push(OP_SHA, 24'h000333, 24'h000444);
      idle(1);
      for (int i = 0; i < DEPTH; i++)
         push(OP_AES_ENC, 24'(i), 24'(i + 8));
      push(OP_SHA, 24'h00ABCD, 24'h00DCBA);
      chk("t3_full_cnt", 64'(queue_count), 64'(DEPTH));
      chk("t3_full_rdy", 64'(bus.cmd_ready), 64'(0));
      pulse(1'b1, 1'b0);
      idle(1);
      chk("t3_rdy_back", 64'(bus.cmd_ready), 64'(1));
      drain();

      // Reserved opcode followed by SHA.
      push(OP_RSVD, 24'h00DEAD, 24'h00BEEF);
      push(OP_SHA, 24'h000777, 24'h000888);
      chk("t4_illegal", 64'({err_illegal, aes_start, sha_start}),
          64'(3'b100));
      idle(1);
      chk("t4_sha", 64'({sha_start, sha_src}), 64'({1'b1, 24'h000777}));
      drain();

      // Reset while AES is busy; a late done must be ignored.
      push(OP_AES_ENC, 24'h000999, 24'h000AAA);
      idle(1);
      do_reset(1);
      pulse(1'b1, 1'b0);
      chk("t6_no_cmpl", 64'(cmpl_valid), 64'(0));
      idle(2);

`ifdef CRYPTO_SCHED_TIMEOUT_EN
      begin
         int k;
         push(OP_SHA, 24'h000123, 24'h000456);
         idle(1);
         for (k = 0; k < 40 && err_timeout !== 1'b1; k++) tick();
         chk("t7_timeout_cycles", 64'(k), 64'(16));
         chk("t7_timeout_core", 64'({cmpl_valid, cmpl_core}), 64'(2'b01));
         idle(2);
      end
`endif

      // Random traffic against the model.
      do_reset(1);
      for (int c = 0; c < 3000; c++) begin
         bus.cmd_valid = ($urandom_range(2) != 0);
         bus.cmd_op  = 2'($urandom_range(3));
         bus.cmd_src = ADDRW'($urandom);
         bus.cmd_dst = ADDRW'($urandom);
         aes_done = busy_m[0] ? (age_m[0] >= 10 || $urandom_range(5) == 0)
                              : ($urandom_range(19) == 0);
         sha_done = busy_m[1] ? (age_m[1] >= 10 || $urandom_range(5) == 0)
                              : ($urandom_range(19) == 0);
         tick();
      end
      bus.cmd_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/crypto_cmd_scheduler.md
Name: crypto_cmd_scheduler

Overview:
- Accepts host crypto commands (AES encrypt/decrypt, SHA hash) into a small in-order queue.
- Dispatches each command to the AES or SHA core with a start/done handshake.
- At most one job is in flight per core; the AES and SHA jobs may overlap in time.
- Sits between the host command decoder and the cores, upstream of bus_arbiter, which later carries the cores' memory traffic.

Parameters:
- ADDRW, 24, width of source and destination addresses.
- DEPTH, 4, command queue depth (power of two, at least 2).
- TIMEOUT_CYCLES, 1024, watchdog limit per job; used only when the timeout feature is compiled in.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue can accept a command
- cmd_op  in  2  00 AES encrypt, 01 AES decrypt, 10 SHA, 11 reserved
- cmd_src  in  ADDRW  source address
- cmd_dst  in  ADDRW  destination address
- aes_start  out  1  one-cycle start pulse to the AES core
- aes_decrypt  out  1  mode qualifier, valid with aes_start
- aes_src / aes_dst  out  ADDRW each  addresses, valid with aes_start
- aes_done  in  1  AES job complete (one-cycle pulse)
- sha_start  out  1  one-cycle start pulse to the SHA core
- sha_src / sha_dst  out  ADDRW each  addresses, valid with sha_start
- sha_done  in  1  SHA job complete (one-cycle pulse)
- cmpl_valid  out  1  one-cycle completion pulse
- cmpl_core  out  1  0 = AES, 1 = SHA; valid with cmpl_valid
- err_illegal  out  1  one-cycle pulse: reserved opcode dropped
- queue_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (synchronous, rst_n low at a clock edge):
  - Queue empties; both core trackers go to IDLE.
  - All pulse outputs 0; addresses and aes_decrypt 0; queue_count 0; cmd_ready 1.
- Reset mid-job: the in-flight job is forgotten. A done arriving after reset is ignored.
- Enqueue:
  - A command is accepted when cmd_valid && cmd_ready. cmd_ready = (queue_count != DEPTH).
  - When full, cmd_ready is 0 even if the head pops in the same cycle (no pass-through).
- Core trackers: one two-state FSM per core, IDLE and BUSY.
  - IDLE -> BUSY on the cycle the start pulse is issued.
  - BUSY -> IDLE on the corresponding done.
  - A done while IDLE is ignored.
- Dispatch is strictly in order, with no reordering around a blocked head:
  - Head is AES op and AES core is IDLE: pop; aes_start = 1 for one cycle; aes_decrypt = op[0]; addresses driven.
  - Head is SHA op and SHA core is IDLE: pop; sha_start = 1; addresses driven.
  - Head's core is BUSY: stall. Later commands wait even if their own core is idle.
  - Head op = 11: pop; err_illegal pulses; no start is issued.
- Start outputs are registered. A command accepted at edge N can drive its start pulse, at the earliest, in the cycle after edge N+1.
- Completion and back-to-back dispatch:
  - done in cycle C frees the core at edge C+1.
  - cmpl_valid/cmpl_core are registered and pulse in the cycle after done.
  - The next start to the same core is issued no earlier than cycle C+1.
- Simultaneous events:
  - aes_done and sha_done in the same cycle: cmpl_valid covers one of them per cycle, with AES reported first. The SHA completion is held in a one-entry pending flag and reported in the next cycle. Neither completion is lost.
  - Push and pop in the same cycle when not full: queue_count is unchanged.
- Address outputs hold their last dispatched value between starts.

Optional Feature:
- Macro: CRYPTO_SCHED_TIMEOUT_EN.
- With the macro defined:
  - Each tracker counts cycles while BUSY.
  - On reaching TIMEOUT_CYCLES without a done, the tracker forces IDLE and pulses an extra output, err_timeout (1 bit), with cmpl_core identifying the core; cmpl_valid stays 0.
  - A done arriving in the same cycle as expiry wins: normal completion, no timeout.
- Without the macro: no counter, no err_timeout port, and BUSY waits indefinitely.

Decomposition:
- Shared package crypto_ctrl_pkg:
  - Opcode localparams OP_AES_ENC = 2'b00, OP_AES_DEC = 2'b01, OP_SHA = 2'b10, OP_RSVD = 2'b11.
  - Core id constants CORE_AES = 0, CORE_SHA = 1.
  - Command width constant 2 + 2*ADDRW.
- Sub-module sync_fifo (params WIDTH, DEPTH): valid/ready push side; peek/pop head side; count output. Reusable elsewhere.

Test Plan:
- Reset, then push {op=00, src=0x000100, dst=0x000200} -> aes_start pulses once with aes_decrypt=0, aes_src=0x000100, aes_dst=0x000200. Drive aes_done 5 cycles later -> cmpl_valid=1, cmpl_core=0 one cycle after done.
- Push AES, then SHA, then AES; hold aes_done low -> AES and SHA start; the second AES stalls at the head with queue_count=1. Pulse aes_done -> second aes_start follows.
- Fill the queue with DEPTH commands while both cores are BUSY -> cmd_ready=0 and a further push is rejected; queue_count=DEPTH. Free the head's core -> cmd_ready returns to 1.
- Push op=11 then op=10 -> err_illegal pulses once with no start; sha_start follows on the next dispatch cycle.
- Pulse aes_done and sha_done in the same cycle -> two consecutive cmpl_valid cycles with cmpl_core 0 then 1.
- Assert rst_n=0 while AES is BUSY, release, then pulse aes_done -> no cmpl_valid. With CRYPTO_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold sha_done -> err_timeout pulses after 16 BUSY cycles.
